// File: rtl/s526n_bist_driver.sv
// BIST driver for the s526n benchmark: LFSR stimulus on {G2,G1,G0}, 16-bit MISR
// compaction of the six benchmark outputs, start/done handshake with abort.
module s526n_bist_driver #(
  parameter int unsigned NUM_CYCLES = 256,
  parameter int unsigned WARMUP     = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  output logic [2:0]  dut_in,
  input  logic [5:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] pat_cnt
);

  typedef enum logic [2:0] {IDLE, WARM, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LAST_PAT  = 16'(NUM_CYCLES - 1);
  localparam logic [15:0] WARM_LOAD = 16'(WARMUP);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] misr;
  logic [15:0] warm_cnt;
  logic [15:0] lfsr_next;
  logic [15:0] misr_next;

  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    misr_next = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]}
                ^ {10'b0, dut_out};
  end

  assign dut_in    = (state == RUN) ? lfsr[2:0] : '0;
  assign signature = misr;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      lfsr     <= '0;
      misr     <= '0;
      pat_cnt  <= '0;
      warm_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lfsr     <= SEED_EFF;
            misr     <= '0;
            pat_cnt  <= '0;
            warm_cnt <= WARM_LOAD;
            busy     <= 1'b1;
            state    <= (WARMUP == 0) ? RUN : WARM;
          end
        end
        WARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt - 16'd1;
            if (warm_cnt == 16'd1) state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            lfsr    <= lfsr_next;
            pat_cnt <= pat_cnt + 16'd1;
            // benchmark outputs lag one cycle: nothing to sample on the first pattern
            if (pat_cnt != 16'd0) misr <= misr_next;
            if (pat_cnt == LAST_PAT) state <= DRAIN;
          end
        end
        DRAIN: begin
          busy <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            misr  <= misr_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s526n_bist_driver.sv
// Scoreboard bench for s526n_bist_driver: three parameterisations, a registered
// benchmark stub, and reference LFSR/MISR models.
module tb_s526n_bist_driver;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        abort = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [5:0]  dut_out_ab = '0;
  logic [5:0]  stub_c;
  logic [2:0]  dut_in_a, dut_in_b, dut_in_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [15:0] sig_a, sig_b, sig_c, pat_a, pat_b, pat_c;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  always #5 CK = ~CK;

  s526n_bist_driver #(.NUM_CYCLES(1), .WARMUP(0), .SEED(16'hACE1)) u_a (
    .CK(CK), .RST(RST), .start(start_a), .abort(abort), .dut_in(dut_in_a),
    .dut_out(dut_out_ab), .busy(busy_a), .done(done_a), .signature(sig_a), .pat_cnt(pat_a));

  s526n_bist_driver #(.NUM_CYCLES(2), .WARMUP(0), .SEED(16'hACE1)) u_b (
    .CK(CK), .RST(RST), .start(start_b), .abort(abort), .dut_in(dut_in_b),
    .dut_out(dut_out_ab), .busy(busy_b), .done(done_b), .signature(sig_b), .pat_cnt(pat_b));

  s526n_bist_driver #(.NUM_CYCLES(256), .WARMUP(4), .SEED(16'hACE1)) u_c (
    .CK(CK), .RST(RST), .start(start_c), .abort(abort), .dut_in(dut_in_c),
    .dut_out(stub_c), .busy(busy_c), .done(done_c), .signature(sig_c), .pat_cnt(pat_c));

  // benchmark stand-in: outputs come straight from flops fed by the inputs
  always_ff @(posedge CK) stub_c <= {dut_in_c, ~dut_in_c};

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, r};
  endfunction

  // signature after the responses to the first n patterns of the seed sequence
  function automatic logic [15:0] model_sig(input int unsigned n);
    logic [15:0] l = 16'hACE1;
    logic [15:0] m = '0;
    for (int unsigned k = 0; k < n; k++) begin
      m = misr_step(m, {l[2:0], ~l[2:0]});
      l = lfsr_step(l);
    end
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic fill_queue_c();
    logic [15:0] l = 16'hACE1;
    exp_q.delete();
    repeat (4) exp_q.push_back(3'b000);
    for (int unsigned k = 0; k < 256; k++) begin
      exp_q.push_back(l[2:0]);
      l = lfsr_step(l);
    end
    exp_q.push_back(3'b000);
  endtask

  task automatic run_b(input logic [5:0] resp, input logic [15:0] exp_sig);
    dut_out_ab = resp;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check_eq("b_run1_dut_in", dut_in_b, 3'b001);
    check_eq("b_run1_busy", busy_b, 1'b1);
    tick();
    check_eq("b_run2_dut_in", dut_in_b, 3'b011);
    tick();
    check_eq("b_drain_dut_in", dut_in_b, 3'b000);
    check_eq("b_drain_busy", busy_b, 1'b1);
    tick();
    check_eq("b_done", done_b, 1'b1);
    check_eq("b_done_busy", busy_b, 1'b0);
    check_eq("b_sig", sig_b, exp_sig);
    check_eq("b_pat_cnt", pat_b, 16'd2);
    tick();
    check_eq("b_done_pulse", done_b, 1'b0);
    check_eq("b_sig_hold", sig_b, exp_sig);
  endtask

  initial begin
    int cnt;
    int guard;

    repeat (2) @(posedge CK);
    #1;
    check_eq("rst_busy", busy_c, 1'b0);
    check_eq("rst_done", done_c, 1'b0);
    check_eq("rst_dut_in", dut_in_c, 3'b000);
    check_eq("rst_sig", sig_c, 16'h0000);
    check_eq("rst_pat_cnt", pat_c, 16'h0000);
    RST = 1'b0;
    tick();

    run_b(6'h01, 16'h0003);
    run_b(6'h00, 16'h0000);

    // single-pattern run
    dut_out_ab = 6'h01;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cnt = 0;
    guard = 0;
    while (busy_a && guard < 20) begin
      cnt++;
      guard++;
      tick();
    end
    check_eq("a_busy_len", cnt, 2);
    check_eq("a_done", done_a, 1'b1);
    check_eq("a_sig", sig_a, 16'h0001);
    check_eq("a_pat_cnt", pat_a, 16'd1);

    // full run with warm-up, a start ignored mid-run
    fill_queue_c();
    start_c = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (i == 0) start_c = 1'b0;
      if (!busy_c) break;
      if (i == 100) start_c = 1'b1;
      if (i == 101) start_c = 1'b0;
      if (exp_q.size() > 0) check_eq("c_dut_in", dut_in_c, exp_q.pop_front());
      cnt++;
    end
    check_eq("c_busy_len", cnt, 261);
    check_eq("c_queue_drained", exp_q.size(), 0);
    check_eq("c_done", done_c, 1'b1);
    check_eq("c_sig", sig_c, model_sig(256));
    check_eq("c_pat_cnt", pat_c, 16'd256);
    tick();
    check_eq("c_done_pulse", done_c, 1'b0);
    check_eq("c_sig_hold", sig_c, model_sig(256));

    // abort at pat_cnt=10
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    guard = 0;
    while (pat_c != 16'd10 && guard < 100) begin
      guard++;
      tick();
    end
    check_eq("abort_reach_10", pat_c, 16'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy_c, 1'b0);
    check_eq("abort_done", done_c, 1'b0);
    check_eq("abort_pat_cnt", pat_c, 16'd10);
    check_eq("abort_sig", sig_c, model_sig(9));
    cnt = 0;
    repeat (5) begin
      tick();
      if (done_c) cnt++;
    end
    check_eq("abort_no_done", cnt, 0);

    // restart after abort reseeds and clears the MISR
    fill_queue_c();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check_eq("restart_pat_cnt", pat_c, 16'd0);
    check_eq("restart_sig", sig_c, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      check_eq("restart_dut_in", dut_in_c, exp_q.pop_front());
    end

    // asynchronous reset between edges, mid-RUN
    #3;
    RST = 1'b1;
    #1;
    check_eq("arst_busy", busy_c, 1'b0);
    check_eq("arst_dut_in", dut_in_c, 3'b000);
    check_eq("arst_sig", sig_c, 16'h0000);
    check_eq("arst_pat_cnt", pat_c, 16'h0000);
    @(negedge CK);
    RST = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (done_c || busy_c) cnt++;
    end
    check_eq("arst_stays_idle", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s526n_bist_driver.md
Name: s526n_bist_driver

Overview:
- Self-test driver for the s526n sequential benchmark, sitting on the other end of its pin interface.
- Generates pseudo-random stimulus on the three benchmark data inputs (G0, G1, G2).
- Compacts the six benchmark outputs (G147, G148, G198, G199, G213, G214) into a 16-bit MISR signature.
- Used to collect oracle responses for locked and unlocked netlists from a start/done handshake.

Parameters:
- NUM_CYCLES, 256: number of stimulus patterns and response samples; legal range 1..65535.
- WARMUP, 4: cycles with dut_in held at 3'b000 before stimulus; 0 skips the warm-up phase.
- SEED, 16'hACE1: LFSR seed loaded on start; a value of 0 is replaced by 16'h0001.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel a run in progress.
- dut_in  out  3  to benchmark {G2,G1,G0}; bit0 drives G0.
- dut_out  in  6  from benchmark {G214,G213,G199,G198,G148,G147}; bit0 is G147.
- busy  out  1  high in WARM, RUN and DRAIN.
- done  out  1  one-cycle pulse when a run completes.
- signature  out  16  MISR value; holds after done.
- pat_cnt  out  16  number of patterns applied in the current run.

Behaviour:
- Reset (asynchronous): state=IDLE; lfsr=0, misr=0, pat_cnt=0, warm counter=0; busy=0, done=0, dut_in=0, signature=0.
- States and transitions:
  - IDLE: when start=1, next state is WARM (or RUN if WARMUP=0). On that edge: lfsr<=SEED (0 maps to 1), misr<=0, pat_cnt<=0, warm counter<=WARMUP.
  - WARM: dut_in=0. The counter decrements each cycle; when it reaches 1, the next state is RUN.
  - RUN: dut_in=lfsr[2:0], combinational from the register. Each cycle lfsr advances and pat_cnt increments.
    - MISR updates in every RUN cycle except the first RUN cycle.
    - After pattern NUM_CYCLES is applied (pat_cnt reaches NUM_CYCLES), the next state is DRAIN.
  - DRAIN: dut_in=0. MISR takes its final sample, so exactly NUM_CYCLES samples are taken in total. Next state is DONE.
  - DONE: done=1 for this single cycle; busy=0. Next state is IDLE.
- One-cycle response alignment: the benchmark outputs come directly from flip-flops, so the response to the pattern applied in cycle k is sampled in cycle k+1.
- LFSR:
  - fb = l[15]^l[13]^l[12]^l[10].
  - l_next = {l[14:0], fb}.
- MISR:
  - mfb = m[15]^m[13]^m[12]^m[10].
  - m_next = {m[14:0], mfb} ^ {10'b0, dut_out}.
- signature is continuously assigned from the MISR register. It stays stable from DONE until the next start.
- Busy duration: start accepted at edge 0 gives busy for exactly WARMUP+NUM_CYCLES+1 cycles. done follows on the next cycle.
- start while busy or in DONE: ignored (no restart, no queueing).
- abort=1 in WARM, RUN or DRAIN: next state is IDLE with done=0; signature and pat_cnt keep their partial values. abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: start wins.
- RST mid-run: immediate return to the reset values listed above; no done pulse.

Test Plan:
- Reset, then WARMUP=0, SEED=16'hACE1, start pulse: first RUN cycle dut_in=3'b001, second RUN cycle dut_in=3'b011 (lfsr=16'h59C3).
- NUM_CYCLES=1, WARMUP=0, dut_out held at 6'h01: busy high for 2 cycles, then done pulse; signature=16'h0001, pat_cnt=1.
- NUM_CYCLES=2, dut_out held at 6'h01: signature=16'h0003. Same run with dut_out held at 6'h00: signature=16'h0000.
- WARMUP=4, NUM_CYCLES=256:
  - dut_in=0 for exactly 4 cycles after start; busy lasts 261 cycles.
  - done is a single-cycle pulse; a start asserted mid-run is ignored.
- abort asserted at pat_cnt=10: returns to IDLE, no done pulse, pat_cnt=10. A new start then restarts with lfsr=SEED, misr=0.
- RST asserted asynchronously mid-RUN, between clock edges: busy, dut_in and signature go to 0 immediately; state is IDLE with no clock edge needed.
